// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Pipeline hazard unit for a 5-stage in-order core. Detects
//            load-use and memory-wait hazards, services taken branches with
//            flushes, and selects ALU operand forwarding paths.
// Build    : HAZARD_FORWARDING_EN defined   -> EX/ME and ME/WB forwarding on;
//                                              only loads in ID/EX stall decode.
//            HAZARD_FORWARDING_EN undefined -> forward selects tied to 00;
//                                              any ID/EX or EX/ME producer of a
//                                              decode source stalls decode.
// Ports    : clk, reset (async, active low)
//            id_rs/id_rt                     - IF/ID source registers
//            id_ex_mem_read/_reg_write/_write_reg - ID/EX producer
//            ex_rs/ex_rt                     - ID/EX source registers
//            ex_me_reg_write/_write_reg      - EX/ME producer
//            me_wb_reg_write/_write_reg      - ME/WB producer
//            mem_access/mem_ready            - data memory handshake
//            branch_taken                    - EX/ME branch resolves taken
//            pc_write, if_id_write, if_id_flush, id_ex_flush, ex_me_flush,
//            pipe_hold                       - stall/flush controls (comb)
//            forward_a/forward_b             - 00 RF, 01 ME/WB, 10 EX/ME
//            state (RUN/STALL/MEM_WAIT), stall_count (saturating, 16 bit)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_write_reg,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_me_reg_write,
  input  logic [4:0]  ex_me_write_reg,
  input  logic        me_wb_reg_write,
  input  logic [4:0]  me_wb_write_reg,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_me_flush,
  output logic        pipe_hold,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic w_mem_stall;
  logic w_load_use;

  // Register 0 is hard-wired zero, so a write to it never creates a hazard.
  function automatic logic prod_match(input logic       we,
                                      input logic [4:0] dst,
                                      input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  assign w_mem_stall = mem_access & ~mem_ready;

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] w_fwd_a, w_fwd_b;

  // Only a load cannot be forwarded in time for the next instruction's EX.
  assign w_load_use = id_ex_mem_read &
                      (prod_match(id_ex_reg_write, id_ex_write_reg, id_rs) |
                       prod_match(id_ex_reg_write, id_ex_write_reg, id_rt));

  // EX/ME is the younger producer, so it is checked last and wins.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (prod_match(me_wb_reg_write, me_wb_write_reg, ex_rs)) w_fwd_a = 2'b01;
    if (prod_match(ex_me_reg_write, ex_me_write_reg, ex_rs)) w_fwd_a = 2'b10;
    if (prod_match(me_wb_reg_write, me_wb_write_reg, ex_rt)) w_fwd_b = 2'b01;
    if (prod_match(ex_me_reg_write, ex_me_write_reg, ex_rt)) w_fwd_b = 2'b10;
  end

  assign forward_a = (pipe_hold || !reset) ? 2'b00 : w_fwd_a;
  assign forward_b = (pipe_hold || !reset) ? 2'b00 : w_fwd_b;
`else
  logic w_unused_fwd;

  // Without bypassing, decode waits until the producer has reached ME/WB
  // (register file written first half, read second half).
  assign w_load_use = prod_match(id_ex_reg_write, id_ex_write_reg, id_rs) |
                      prod_match(id_ex_reg_write, id_ex_write_reg, id_rt) |
                      prod_match(ex_me_reg_write, ex_me_write_reg, id_rs) |
                      prod_match(ex_me_reg_write, ex_me_write_reg, id_rt);

  assign forward_a = 2'b00;
  assign forward_b = 2'b00;

  assign w_unused_fwd = ^{ex_rs, ex_rt, me_wb_reg_write, me_wb_write_reg,
                          id_ex_mem_read};
`endif

  // Control outputs and next state; priority mem_stall > branch > load_use.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    pipe_hold   = 1'b0;
    state_d     = RUN;

    case (state_q)
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_me_flush = 1'b1;
        end
      end
      default: begin  // RUN and STALL share the same decision tree
        if (w_mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = MEM_WAIT;
        end else if (branch_taken) begin
          // Redirect discards any pending load-use on the wrong path.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_me_flush = 1'b1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = STALL;
        end
      end
    endcase

    // In reset the pipeline is frozen and every stage register is flushed.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
      pipe_hold   = 1'b0;
      state_d     = RUN;
    end
  end

  assign stall_count_d = (!pc_write && (stall_count_q != 16'hFFFF)) ?
                         stall_count_q + 16'd1 : stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed, table-driven bench for hazard_controller. Expectations
//            adapt to whether HAZARD_FORWARDING_EN is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_STL = 2'b01;
  localparam logic [1:0] S_MW  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_ex_write_reg, ex_rs, ex_rt;
  logic [4:0]  ex_me_write_reg, me_wb_write_reg;
  logic        id_ex_mem_read, id_ex_reg_write, ex_me_reg_write, me_wb_reg_write;
  logic        mem_access, mem_ready, branch_taken;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_me_flush;
  logic        pipe_hold;
  logic [1:0]  forward_a, forward_b, state;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write),
    .id_ex_write_reg(id_ex_write_reg),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_me_reg_write(ex_me_reg_write),
    .ex_me_write_reg(ex_me_write_reg),
    .me_wb_reg_write(me_wb_reg_write),
    .me_wb_write_reg(me_wb_write_reg),
    .mem_access     (mem_access),
    .mem_ready      (mem_ready),
    .branch_taken   (branch_taken),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_me_flush    (ex_me_flush),
    .pipe_hold      (pipe_hold),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .state          (state),
    .stall_count    (stall_count)
  );

  // ff = {if_id_flush, id_ex_flush, ex_me_flush}
  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       mr;
    logic       rw;
    logic [4:0] wr;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       xrw;
    logic [4:0] xwr;
    logic       wrw;
    logic [4:0] wwr;
    logic       acc;
    logic       rdy;
    logic       br;
    logic       pc;
    logic       ifid;
    logic [2:0] ff;
    logic       hold;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string t, input logic pc, input logic ifid,
                         input logic [2:0] ff, input logic hold,
                         input logic [1:0] fa, input logic [1:0] fb);
    chk({t, ".pc_write"},    {31'd0, pc_write},    {31'd0, pc});
    chk({t, ".if_id_write"}, {31'd0, if_id_write}, {31'd0, ifid});
    chk({t, ".flushes"},     {29'd0, if_id_flush, id_ex_flush, ex_me_flush}, {29'd0, ff});
    chk({t, ".pipe_hold"},   {31'd0, pipe_hold},   {31'd0, hold});
    chk({t, ".forward_a"},   {30'd0, forward_a},   {30'd0, fa});
    chk({t, ".forward_b"},   {30'd0, forward_b},   {30'd0, fb});
  endtask

  task automatic chk_st(input string t, input logic [1:0] st, input logic [15:0] cnt);
    chk({t, ".state"},       {30'd0, state},       {30'd0, st});
    chk({t, ".stall_count"}, {16'd0, stall_count}, {16'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0;
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; id_ex_write_reg = 5'd0;
    ex_rs = 5'd0; ex_rt = 5'd0;
    ex_me_reg_write = 1'b0; ex_me_write_reg = 5'd0;
    me_wb_reg_write = 1'b0; me_wb_write_reg = 5'd0;
    mem_access = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt;
    id_ex_mem_read = v.mr; id_ex_reg_write = v.rw; id_ex_write_reg = v.wr;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_me_reg_write = v.xrw; ex_me_write_reg = v.xwr;
    me_wb_reg_write = v.wrw; me_wb_write_reg = v.wwr;
    mem_access = v.acc; mem_ready = v.rdy; branch_taken = v.br;
  endtask

  initial begin
    //            id_rs  id_rt  mr   rw   wr     ex_rs  ex_rt  xrw  xwr    wrw  wwr    acc  rdy  br   pc   ifid ff      hold fa     fb     st
    vecs[0]  = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b00,2'b00,S_RUN};
    vecs[1]  = '{5'd8, 5'd0, 1'b1,1'b1,5'd8, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,3'b010,1'b0,2'b00,2'b00,S_STL};
    vecs[2]  = '{5'd0, 5'd8, 1'b1,1'b1,5'd8, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,3'b010,1'b0,2'b00,2'b00,S_STL};
    vecs[3]  = '{5'd0, 5'd0, 1'b1,1'b1,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b00,2'b00,S_RUN};
    vecs[4]  = '{5'd8, 5'd8, 1'b1,1'b0,5'd8, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b00,2'b00,S_RUN};
    vecs[5]  = '{5'd8, 5'd0, 1'b1,1'b1,5'd8, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,1'b0,1'b1, 1'b0,1'b0,3'b000,1'b1,2'b00,2'b00,S_MW};
    vecs[6]  = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b00,2'b00,S_RUN};
    vecs[7]  = '{5'd8, 5'd0, 1'b1,1'b1,5'd8, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0,1'b1,1'b1, 1'b1,1'b1,3'b111,1'b0,2'b00,2'b00,S_RUN};
    vecs[8]  = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd9, 5'd0, 1'b1,5'd9, 1'b1,5'd9, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b10,2'b00,S_RUN};
    vecs[9]  = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd9, 5'd0, 1'b0,5'd9, 1'b1,5'd9, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b01,2'b00,S_RUN};
    vecs[10] = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,5'd0, 1'b1,5'd0, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b00,2'b00,S_RUN};
    vecs[11] = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd6, 5'd5, 1'b1,5'd5, 1'b1,5'd6, 1'b0,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,2'b01,2'b10,S_RUN};
    vecs[12] = '{5'd0, 5'd0, 1'b0,1'b0,5'd0, 5'd9, 5'd0, 1'b1,5'd9, 1'b1,5'd9, 1'b1,1'b0,1'b0, 1'b0,1'b0,3'b000,1'b1,2'b00,2'b00,S_MW};

    // Reset values, with a forwarding match present on the inputs.
    reset = 1'b0;
    clear_in();
    apply(vecs[8]);
    #2;
    chk_out("rst", 1'b0, 1'b0, 3'b111, 1'b0, 2'b00, 2'b00);
    chk_st("rst", S_RUN, 16'd0);
    tick();
    tick();
    chk_st("rst_held", S_RUN, 16'd0);
    reset = 1'b1;
    #1;

    // Single-cycle vectors, each from a fresh RUN state.
    for (int i = 0; i < NV; i++) begin
      clear_in();
      rst_pulse();
      apply(vecs[i]);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].ff,
              vecs[i].hold, FWD ? vecs[i].fa : 2'b00, FWD ? vecs[i].fb : 2'b00);
      tick();
      chk_st($sformatf("v%0d", i), vecs[i].st, {15'd0, ~vecs[i].pc});
    end

    // Load-use: load in ID/EX, then it moves to EX/ME, then to ME/WB.
    clear_in();
    rst_pulse();
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd8; id_rs = 5'd8;
    #1;
    chk_out("lu0", 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("lu0", S_STL, 16'd1);
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; id_ex_write_reg = 5'd0;
    ex_me_reg_write = 1'b1; ex_me_write_reg = 5'd8;
    #1;
    chk_out("lu1", FWD, FWD, FWD ? 3'b000 : 3'b010, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("lu1", FWD ? S_RUN : S_STL, FWD ? 16'd1 : 16'd2);
    ex_me_reg_write = 1'b0; ex_me_write_reg = 5'd0;
    me_wb_reg_write = 1'b1; me_wb_write_reg = 5'd8;
    #1;
    chk_out("lu2", 1'b1, 1'b1, 3'b000, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("lu2", S_RUN, FWD ? 16'd1 : 16'd2);

    // ALU producer feeding id_rt, walking ID/EX -> EX/ME -> ME/WB.
    clear_in();
    rst_pulse();
    id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd7; id_rt = 5'd7;
    #1;
    chk_out("alu0", FWD, FWD, FWD ? 3'b000 : 3'b010, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("alu0", FWD ? S_RUN : S_STL, FWD ? 16'd0 : 16'd1);
    id_ex_reg_write = 1'b0; id_ex_write_reg = 5'd0;
    ex_me_reg_write = 1'b1; ex_me_write_reg = 5'd7; ex_rt = 5'd7;
    #1;
    chk_out("alu1", FWD, FWD, FWD ? 3'b000 : 3'b010, 1'b0, 2'b00, FWD ? 2'b10 : 2'b00);
    tick();
    chk_st("alu1", FWD ? S_RUN : S_STL, FWD ? 16'd0 : 16'd2);
    ex_me_reg_write = 1'b0; ex_me_write_reg = 5'd0;
    me_wb_reg_write = 1'b1; me_wb_write_reg = 5'd7;
    #1;
    chk_out("alu2", 1'b1, 1'b1, 3'b000, 1'b0, 2'b00, FWD ? 2'b01 : 2'b00);
    tick();
    chk_st("alu2", S_RUN, FWD ? 16'd0 : 16'd2);

    // Memory wait for three cycles, released together with a taken branch.
    clear_in();
    rst_pulse();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("mw%0d", i), 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 2'b00);
      tick();
      chk({$sformatf("mw%0d", i), ".state"}, {30'd0, state}, {30'd0, S_MW});
    end
    chk_st("mw_end", S_MW, 16'd3);
    mem_ready = 1'b1; branch_taken = 1'b1;
    #1;
    chk_out("mw_exit", 1'b1, 1'b1, 3'b111, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("mw_exit", S_RUN, 16'd3);

    // STALL: branch beats a persisting load-use, then mem stall beats load-use.
    clear_in();
    rst_pulse();
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd3; id_rt = 5'd3;
    tick();
    chk_st("stl_in", S_STL, 16'd1);
    branch_taken = 1'b1;
    #1;
    chk_out("stl_br", 1'b1, 1'b1, 3'b111, 1'b0, 2'b00, 2'b00);
    tick();
    chk_st("stl_br", S_RUN, 16'd1);
    branch_taken = 1'b0;
    tick();
    chk_st("stl_in2", S_STL, 16'd2);
    mem_access = 1'b1; mem_ready = 1'b0;
    #1;
    chk_out("stl_mem", 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 2'b00);
    tick();
    chk_st("stl_mem", S_MW, 16'd3);

    // Saturation over 70000 held cycles, then asynchronous reset mid-wait.
    clear_in();
    rst_pulse();
    mem_access = 1'b1; mem_ready = 1'b0;
    repeat (70000) tick();
    chk_st("sat", S_MW, 16'hFFFF);
    #2;
    reset = 1'b0;
    #1;
    chk_st("async_rst", S_RUN, 16'd0);
    chk_out("async_rst", 1'b0, 1'b0, 3'b111, 1'b0, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    chk_out("post_rst", 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 2'b00);
    tick();
    chk_st("post_rst", S_MW, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; reset input 1, asynchronous active-low reset.
REQ-002 Decode-stage sources SHALL be id_rs input 5 and id_rt input 5, the source registers of the instruction in IF/ID.
REQ-003 ID/EX producer ports SHALL be id_ex_mem_read input 1, id_ex_reg_write input 1 and id_ex_write_reg input 5, the load flag, write flag and destination of the instruction in ID/EX.
REQ-004 Execute-stage sources SHALL be ex_rs input 5 and ex_rt input 5, the source registers of the instruction in ID/EX.
REQ-005 EX/ME producer ports SHALL be ex_me_reg_write input 1 and ex_me_write_reg input 5.
REQ-006 ME/WB producer ports SHALL be me_wb_reg_write input 1 and me_wb_write_reg input 5.
REQ-007 Memory ports SHALL be mem_access input 1, meaning EX/ME holds a memory read or write, and mem_ready input 1, meaning data memory completes this cycle.
REQ-008 branch_taken input 1 SHALL mean that the EX/ME branch target is valid and taken this cycle.
REQ-009 Stall and flush outputs SHALL be pc_write output 1, if_id_write output 1, if_id_flush output 1, id_ex_flush output 1, ex_me_flush output 1 and pipe_hold output 1; pipe_hold holds ID/EX, EX/ME and ME/WB.
REQ-010 Forward selects SHALL be forward_a output 2 and forward_b output 2: 00 register file, 01 ME/WB, 10 EX/ME.
REQ-011 Status outputs SHALL be state output 2 (RUN=00, STALL=01, MEM_WAIT=10) and stall_count output 16, the saturating count of non-advancing cycles.

Function
REQ-012 Stall, flush and forward outputs SHALL be combinational from state and inputs; state and stall_count SHALL be registered on the rising edge of clk.
REQ-013 A producer SHALL match a source register only when its write flag is 1, its destination is nonzero and its destination equals that source.
REQ-014 load_use SHALL be id_ex_mem_read AND an ID/EX producer match on id_rs or id_rt.
REQ-015 mem_stall SHALL be mem_access AND NOT mem_ready.
REQ-016 Priority SHALL be mem_stall > branch_taken > load_use.
REQ-017 RUN, mem_stall: outputs SHALL be pc_write=0, if_id_write=0, pipe_hold=1, all flushes 0; next state SHALL be MEM_WAIT.
REQ-018 MEM_WAIT SHALL drive the outputs of REQ-017 while mem_ready=0.
REQ-019 MEM_WAIT, mem_ready=1: outputs SHALL be normal advance and next state SHALL be RUN; a branch_taken in the same cycle SHALL be serviced per REQ-020.
REQ-020 RUN, branch_taken with no mem_stall: outputs SHALL be if_id_flush=1, id_ex_flush=1, ex_me_flush=1, pc_write=1 (PC loads target); next state SHALL be RUN; a concurrent load_use SHALL be discarded.
REQ-021 RUN, load_use only: outputs SHALL be pc_write=0, if_id_write=0, id_ex_flush=1 (bubble); next state SHALL be STALL.
REQ-022 STALL: load_use is re-evaluated each cycle; the block SHALL remain in STALL with the REQ-021 outputs while a hazard holds, else advance normally and return to RUN; mem_stall and branch_taken in STALL SHALL take priority per REQ-016.
REQ-023 Normal advance SHALL be pc_write=1, if_id_write=1, all flushes 0, pipe_hold=0.
REQ-024 stall_count SHALL increment on every cycle with pc_write=0 and SHALL saturate at 0xFFFF with no wrap.
REQ-025 The forward_a source SHALL be ex_rs and the forward_b source SHALL be ex_rt; an EX/ME match SHALL select 10, else an ME/WB match SHALL select 01, else 00; when both match, EX/ME SHALL win.
REQ-026 forward_a and forward_b SHALL be 00 while pipe_hold=1.

Reset
REQ-027 While reset=0 the outputs SHALL be: state=RUN, stall_count=0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_me_flush=1, pipe_hold=0, forward_a=00, forward_b=00.
REQ-028 Reset SHALL take effect immediately, including mid-STALL or mid-MEM_WAIT; the first edge after release SHALL evaluate from RUN.

Configuration
REQ-029 Macro HAZARD_FORWARDING_EN SHALL select forwarding.
REQ-030 Defined: the block SHALL behave per REQ-014 and REQ-025.
REQ-031 Undefined: forward_a and forward_b SHALL be tied to 00.
REQ-032 Undefined: load_use SHALL be any ID/EX or EX/ME producer match on id_rs or id_rt regardless of mem_read, so STALL lasts until the producer reaches ME/WB (up to 2 cycles).

Verification
REQ-033 Load-use: id_ex_mem_read=1, id_ex_reg_write=1, id_ex_write_reg=8, id_rs=8 -> one cycle pc_write=0 and id_ex_flush=1, state STALL then RUN, stall_count=1.
REQ-034 Forwarding: ex_me_write_reg=ex_rs=9 and me_wb_write_reg=ex_rs=9, both write flags 1 -> forward_a=10; ex_me_reg_write=0 -> forward_a=01; register 0 -> 00.
REQ-035 Memory wait: mem_access=1, mem_ready=0 for 3 cycles -> pipe_hold=1 and state MEM_WAIT for 3 cycles, stall_count=3; mem_ready=1 -> RUN.
REQ-036 Branch with load_use in the same cycle -> all three flushes=1, pc_write=1, state remains RUN.
REQ-037 Saturation and reset: hold mem_stall for 70000 cycles -> stall_count=0xFFFF; assert reset mid-MEM_WAIT -> state=RUN and stall_count=0 immediately.
REQ-038 Without HAZARD_FORWARDING_EN: ALU producer in ID/EX, id_rt=its destination -> 2 stall cycles, forward_a and forward_b stay 00.
